// File: rtl/data_sram_responder_if.sv
// Sram-like data-memory port: req/addr_ok request handshake plus data_ok/rdata response.
interface data_sram_responder_if;
    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;

    modport master (
        output data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
               data_sram_addr, data_sram_wdata,
        input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
    );

    modport slave (
        input  data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
               data_sram_addr, data_sram_wdata,
        output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
    );
endinterface

// File: rtl/data_sram_responder.sv
// Data RAM responder: byte-masked writes / word reads on a synchronous array, answered in
// order after a fixed LATENCY with at most MAX_OUT requests outstanding.
module data_sram_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 1,
    parameter int MAX_OUT    = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    data_sram_responder_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
        $fatal(1, "data_sram_responder: LATENCY must be in 1..8");
    end
    if (MAX_OUT < 1 || MAX_OUT > 8) begin : g_bad_max_out
        $fatal(1, "data_sram_responder: MAX_OUT must be in 1..8");
    end
    if (DEPTH_LOG2 < 1 || DEPTH_LOG2 > 29) begin : g_bad_depth
        $fatal(1, "data_sram_responder: DEPTH_LOG2 must be in 1..29");
    end

    logic                  addr_ok;
    logic                  accept;
    logic [DEPTH_LOG2-1:0] word_idx;
    logic [3:0]            count_reg;
    logic [3:0]            count_next;
    logic [LATENCY-1:0]    valid_reg;
    logic [LATENCY-1:0]    valid_next;
    logic [LATENCY-1:0]    wr_reg;
    logic [LATENCY-1:0]    wr_next;
    logic [31:0]           data_pipe [LATENCY];
    logic [31:0]           mem [DEPTH];
    logic                  data_ok_reg;
    logic [31:0]           rdata_reg;
    logic                  unused_bits;

    assign addr_ok  = resetn && (count_reg < 4'(MAX_OUT));
    assign accept   = bus.data_sram_req && addr_ok;
    assign word_idx = bus.data_sram_addr[DEPTH_LOG2+1:2];

    // size is informational (wstrb governs); sub-word and above-index address bits alias away
    assign unused_bits = ^{bus.data_sram_size, bus.data_sram_addr[1:0],
                           bus.data_sram_addr[31:DEPTH_LOG2+2]};

    assign bus.data_sram_addr_ok = addr_ok;
    assign bus.data_sram_data_ok = data_ok_reg;
    assign bus.data_sram_rdata   = rdata_reg;

    genvar gi;
    for (gi = 0; gi < LATENCY; gi++) begin : g_stage
        if (gi == 0) begin : g_head
            assign valid_next[gi] = accept;
            assign wr_next[gi]    = bus.data_sram_wr;
        end else begin : g_tail
            assign valid_next[gi] = valid_reg[gi-1];
            assign wr_next[gi]    = wr_reg[gi-1];
        end
    end

    // Array and read-data pipeline carry no reset so the array maps onto block RAM;
    // the data words are only ever observed through the reset-cleared valid bits.
    always_ff @(posedge clk) begin
        if (accept && bus.data_sram_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.data_sram_wstrb[b]) begin
                    mem[word_idx][8*b +: 8] <= bus.data_sram_wdata[8*b +: 8];
                end
            end
        end
        if (accept && !bus.data_sram_wr) begin
            data_pipe[0] <= mem[word_idx];
        end
        for (int k = 1; k < LATENCY; k++) begin
            data_pipe[k] <= data_pipe[k-1];
        end
    end

    always_comb begin
        count_next = count_reg;
        case ({accept, data_ok_reg})
            2'b10:   count_next = count_reg + 4'd1;
            2'b01:   count_next = count_reg - 4'd1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_reg   <= '0;
            valid_reg   <= '0;
            wr_reg      <= '0;
            data_ok_reg <= 1'b0;
            rdata_reg   <= '0;
        end else begin
            count_reg   <= count_next;
            valid_reg   <= valid_next;
            wr_reg      <= wr_next;
            data_ok_reg <= valid_reg[LATENCY-1];
            rdata_reg   <= (valid_reg[LATENCY-1] && !wr_reg[LATENCY-1])
                           ? data_pipe[LATENCY-1] : 32'h0;
        end
    end
endmodule
